// File: rtl/uart_alu_pkg.sv
// Shared types and defaults for the UART-to-ALU byte collector.
// The optional inter-byte timeout is enabled with UART_ALU_INTF_TIMEOUT_EN.
package uart_alu_pkg;

    localparam int NB_DATA_DEF     = 32'sd8;
    localparam int NB_OP_DEF       = 32'sd6;
    localparam int TIMEOUT_CYC_DEF = 32'sd1000000;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CALC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    // Counter width able to hold 0 .. cycles-1, never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        if (cycles > 32'sd2) begin
            cnt_width = $clog2(cycles);
        end else begin
            cnt_width = 32'sd1;
        end
    endfunction

    localparam int TO_CNT_W = cnt_width(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/uart_alu_intf_timeout.sv
// Inter-byte watchdog: counts enabled cycles and flags the terminal count.
// Only instantiated when UART_ALU_INTF_TIMEOUT_EN is defined.
module intf_timeout
    import uart_alu_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = cnt_width(TIMEOUT_CYC)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] PRE_TERMINAL = CNT_W'(TIMEOUT_CYC - 32'sd2);

    logic [CNT_W-1:0] count_r;
    logic             expire_r;

    // expire_r rises together with count_r reaching TIMEOUT_CYC-1, so the flag stays registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r  <= {CNT_W{1'b0}};
            expire_r <= 1'b0;
        end else if (clear || !enable || expire_r) begin
            count_r  <= {CNT_W{1'b0}};
            expire_r <= 1'b0;
        end else begin
            count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            expire_r <= (count_r == PRE_TERMINAL);
        end
    end

    assign expire = expire_r;

endmodule

// File: rtl/uart_alu_intf.sv
// Collects operand A, operand B and opcode from the UART receiver, then ships the ALU result to the transmitter.
// Optional inter-byte timeout: define UART_ALU_INTF_TIMEOUT_EN.
module uart_alu_intf
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int NB_OP       = NB_OP_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done_tick,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic [NB_DATA-1:0] alu_result,
    input  logic               tx_done_tick,
    output logic [NB_DATA-1:0] alu_data_a,
    output logic [NB_DATA-1:0] alu_data_b,
    output logic [NB_OP-1:0]   alu_op,
    output logic [NB_DATA-1:0] tx_data,
    output logic               tx_start,
    output logic               busy
);

    state_t state_r;
    logic   expire_s;

`ifdef UART_ALU_INTF_TIMEOUT_EN
    logic timeout_en_s;
    logic timeout_clr_s;

    // Watchdog runs only while a transaction is partially received.
    always_comb begin
        timeout_en_s  = 1'b0;
        timeout_clr_s = 1'b0;
        if ((state_r == WAIT_B) || (state_r == WAIT_OP)) begin
            timeout_en_s  = 1'b1;
            timeout_clr_s = rx_done_tick;
        end else begin
            timeout_en_s  = 1'b0;
            timeout_clr_s = 1'b0;
        end
    end

    intf_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (timeout_clr_s),
        .enable (timeout_en_s),
        .expire (expire_s)
    );
`else
    logic unused_timeout_cfg_s;

    assign unused_timeout_cfg_s = ^TIMEOUT_CYC;
    assign expire_s             = 1'b0;
`endif

    // Transaction FSM; a received byte always takes priority over a coincident timeout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= WAIT_A;
            alu_data_a <= {NB_DATA{1'b0}};
            alu_data_b <= {NB_DATA{1'b0}};
            alu_op     <= {NB_OP{1'b0}};
            tx_data    <= {NB_DATA{1'b0}};
            tx_start   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state_r)
                WAIT_A: begin
                    if (rx_done_tick) begin
                        alu_data_a <= rx_data;
                        state_r    <= WAIT_B;
                    end else begin
                        state_r    <= WAIT_A;
                    end
                end
                WAIT_B: begin
                    if (rx_done_tick) begin
                        alu_data_b <= rx_data;
                        state_r    <= WAIT_OP;
                    end else if (expire_s) begin
                        state_r    <= WAIT_A;
                    end else begin
                        state_r    <= WAIT_B;
                    end
                end
                WAIT_OP: begin
                    if (rx_done_tick) begin
                        alu_op  <= rx_data[NB_OP-1:0];
                        busy    <= 1'b1;
                        state_r <= CALC;
                    end else if (expire_s) begin
                        state_r <= WAIT_A;
                    end else begin
                        state_r <= WAIT_OP;
                    end
                end
                CALC: begin
                    tx_data  <= alu_result;
                    tx_start <= 1'b1;
                    state_r  <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done_tick) begin
                        busy    <= 1'b0;
                        state_r <= WAIT_A;
                    end else begin
                        state_r <= WAIT_TX;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_intf.sv
// Randomized scoreboard bench for uart_alu_intf against a byte-level protocol model.
`timescale 1ns/1ps
module tb_uart_alu_intf;

    localparam int NB_DATA     = 8;
    localparam int NB_OP       = 6;
    localparam int TIMEOUT_CYC = 100;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               rx_done_tick = 1'b0;
    logic [NB_DATA-1:0] rx_data = 8'h00;
    logic [NB_DATA-1:0] alu_result;
    logic               tx_done_tick = 1'b0;
    logic [NB_DATA-1:0] alu_data_a;
    logic [NB_DATA-1:0] alu_data_b;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               busy;

    always #5 clk = ~clk;

    uart_alu_intf #(
        .NB_DATA     (NB_DATA),
        .NB_OP       (NB_OP),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .alu_result   (alu_result),
        .tx_done_tick (tx_done_tick),
        .alu_data_a   (alu_data_a),
        .alu_data_b   (alu_data_b),
        .alu_op       (alu_op),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .busy         (busy)
    );

    // Behavioural ALU standing in for the real one.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   alu_fn = a + b;
            6'h22:   alu_fn = a - b;
            6'h24:   alu_fn = a & b;
            6'h25:   alu_fn = a | b;
            6'h26:   alu_fn = a ^ b;
            6'h27:   alu_fn = ~(a | b);
            6'h03:   alu_fn = 8'($signed(a) >>> b[2:0]);
            6'h02:   alu_fn = a >> b[2:0];
            default: alu_fn = 8'h00;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_data_a, alu_data_b, alu_op);

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bytes collected so far, and edges elapsed since the opcode was accepted.
    logic [7:0] m_a, m_b, m_tx, m_pend;
    logic [5:0] m_op;
    int         m_cnt, m_since, m_idle;
    bit         m_busy;
    logic [7:0] sb_q[$];
    logic [7:0] sb_exp;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst_v, input bit rx, input logic [7:0] d, input bit txd);
        if (rst_v) begin
            m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00; m_pend = 8'h00;
            m_cnt = 0; m_since = -1; m_idle = 0; m_busy = 1'b0;
            sb_q.delete();
        end else if (m_since == 0) begin
            m_tx    = m_pend;
            m_since = 1;
        end else if (m_since >= 1) begin
            if (txd) begin
                m_since = -1;
                m_busy  = 1'b0;
            end else begin
                m_since++;
            end
        end else if (rx) begin
            m_idle = 0;
            if (m_cnt == 0) begin
                m_a = d; m_cnt = 1;
            end else if (m_cnt == 1) begin
                m_b = d; m_cnt = 2;
            end else begin
                m_op   = d[5:0];
                m_pend = alu_fn(m_a, m_b, m_op);
                sb_q.push_back(m_pend);
                m_since = 0;
                m_busy  = 1'b1;
                m_cnt   = 0;
            end
        end else begin
`ifdef UART_ALU_INTF_TIMEOUT_EN
            if (m_cnt != 0) begin
                m_idle++;
                if (m_idle == TIMEOUT_CYC) begin
                    m_cnt  = 0;
                    m_idle = 0;
                end
            end
`endif
        end
    endtask

    // One clock of stimulus; inputs change 1 ns after the edge that sampled them.
    task automatic tick(input bit rst_v, input bit rx, input logic [7:0] d, input bit txd);
        reset        = rst_v ? 1'b0 : 1'b1;
        rx_done_tick = rx;
        rx_data      = d;
        tx_done_tick = txd;
        @(posedge clk);
        model_edge(rst_v, rx, d, txd);
        #1;
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        rx_data      = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic send(input logic [7:0] d);
        tick(1'b0, 1'b1, d, 1'b0);
        idle($urandom_range(0, 2));
    endtask

    task automatic finish_tx();
        idle(3);
        tick(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    // Monitor: per-cycle register checks plus scoreboard pop on each transmit request.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("alu_data_a", 32'(alu_data_a), 32'(m_a));
            chk("alu_data_b", 32'(alu_data_b), 32'(m_b));
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("tx_start", 32'(tx_start), 32'(m_since == 1));
            chk("tx_data", 32'(tx_data), 32'(m_tx));
            if (tx_start === 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_unexpected_tx: got tx_start=1 expected no pending result at %0t", $time);
                end else begin
                    sb_exp = sb_q.pop_front();
                    chk("sb_result", 32'(tx_data), 32'(sb_exp));
                end
            end
        end
    end

    initial begin
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        mon_en = 1'b1;
        tick(1'b1, 1'b1, 8'h99, 1'b0);
        chk("reset_tx_data", 32'(tx_data), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // ADD transaction with explicit latency checks.
        send(8'h05); send(8'h03);
        tick(1'b0, 1'b1, 8'h20, 1'b0);
        chk("add_op", 32'(alu_op), 32'h20);
        chk("add_start_low", 32'(tx_start), 32'h0);
        idle(1);
        chk("add_tx_data", 32'(tx_data), 32'h08);
        chk("add_start_high", 32'(tx_start), 32'h1);
        idle(1);
        chk("add_start_one_cycle", 32'(tx_start), 32'h0);
        chk("add_busy", 32'(busy), 32'h1);
        finish_tx();
        chk("add_idle", 32'(busy), 32'h0);

        // Opcode truncation.
        send(8'h09); send(8'h04); send(8'hE2);
        chk("trunc_op", 32'(alu_op), 32'h22);
        finish_tx();

        // Byte during WAIT_TX is dropped.
        send(8'h01); send(8'h02); send(8'h20);
        idle(2);
        tick(1'b0, 1'b1, 8'hAA, 1'b0);
        chk("drop_a", 32'(alu_data_a), 32'h01);
        finish_tx();
        send(8'h01); send(8'h02); send(8'h20);
        idle(2);
        chk("drop_next_tx", 32'(tx_data), 32'h03);
        finish_tx();

        // Mid-transaction reset.
        send(8'h7F);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        chk("midrst_a", 32'(alu_data_a), 32'h0);
        send(8'h11); send(8'h22); send(8'h20);
        finish_tx();

        // Back-to-back: byte coinciding with tx_done is dropped.
        send(8'h0A); send(8'h0B); send(8'h26);
        idle(3);
        tick(1'b0, 1'b1, 8'h55, 1'b1);
        chk("b2b_drop", 32'(alu_data_a), 32'h0A);
        send(8'h33);
        chk("b2b_capture", 32'(alu_data_a), 32'h33);
        send(8'h44); send(8'h20);
        finish_tx();

`ifdef UART_ALU_INTF_TIMEOUT_EN
        tick(1'b0, 1'b1, 8'h10, 1'b0);
        idle(TIMEOUT_CYC);
        tick(1'b0, 1'b1, 8'h21, 1'b0);
        chk("to_new_a", 32'(alu_data_a), 32'h21);
        idle(TIMEOUT_CYC - 1);
        tick(1'b0, 1'b1, 8'h66, 1'b0);
        chk("to_edge_b", 32'(alu_data_b), 32'h66);
        send(8'h20);
        finish_tx();
`endif

        // Randomized traffic including stray ticks and rare resets.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                 8'($urandom), $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 4 && m_since >= 0; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
        idle(1);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
